// File: rtl/ddr_frame_writer_if.sv
// rtl/ddr_frame_writer_if.sv - DDR write-burst request/data bus between frame writer and controller
`timescale 1ns/1ps
interface ddr_frame_writer_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int LEN_WIDTH  = 16,
    parameter int BEAT_WIDTH = 256
);
    logic                  ddr_wreq;
    logic [ADDR_WIDTH-1:0] ddr_waddr;
    logic [LEN_WIDTH-1:0]  ddr_wr_len;
    logic                  ddr_wrdy;
    logic                  ddr_wdata_req;
    logic [BEAT_WIDTH-1:0] ddr_wdata;
    logic                  ddr_wdone;

    modport master (
        output ddr_wreq, ddr_waddr, ddr_wr_len, ddr_wdata,
        input  ddr_wrdy, ddr_wdata_req, ddr_wdone
    );
    modport slave (
        input  ddr_wreq, ddr_waddr, ddr_wr_len, ddr_wdata,
        output ddr_wrdy, ddr_wdata_req, ddr_wdone
    );
endinterface

// File: rtl/ddr_frame_writer.sv
// rtl/ddr_frame_writer.sv - line-buffered 128b pixel stream to 256b DDR line bursts, ping-pong banks
`timescale 1ns/1ps
module ddr_frame_writer #(
    parameter int          ADDR_WIDTH      = 27,
    parameter logic [31:0] ADDR_OFFSET     = 32'h0,
    parameter int          H_NUM           = 1920,
    parameter int          V_NUM           = 1080,
    parameter int          DQ_WIDTH        = 32,
    parameter int          LEN_WIDTH       = 16,
    parameter int          PIX_WIDTH       = 24,
    parameter int          LINE_ADDR_WIDTH = 21
) (
    input  logic                 ddr_clk,
    input  logic                 ddr_rstn,
    input  logic                 init_done,
    input  logic                 wr_fsync,
    input  logic                 wr_en,
    input  logic [127:0]         wr_data,
    output logic                 wr_ready,
    ddr_frame_writer_if.master   ddr,
    output logic                 o_wr_frame_bit,
    output logic                 o_frame_done,
    output logic                 o_overflow
);
    localparam int WPL       = H_NUM * PIX_WIDTH / 128;
    localparam int BPL       = WPL * 128 / 256;
    localparam int LINE_STEP = BPL * 256 / DQ_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_DONE} state_t;

    state_t                     state;
    logic [127:0]               mem [0:1023];
    logic [9:0]                 wptr, rptr;
    logic [10:0]                fill;
    logic                       wr_fsync_d, wdone_d, fs_pend, frame_full;
    logic [LEN_WIDTH-1:0]       beat_cnt;
    logic [15:0]                line_cnt;
    logic [LINE_ADDR_WIDTH-1:0] line_addr;
    logic                       fs_rise, wdone_rise, push, pop;

    assign fs_rise    = wr_fsync & ~wr_fsync_d;
    assign wdone_rise = ddr.ddr_wdone & ~wdone_d;
    assign fill       = {1'b0, wptr - rptr};
    // Gated by reset so the upstream stalls while the block is held in reset.
    assign wr_ready   = ddr_rstn & init_done & ~fs_pend & ~frame_full & (fill < 11'd1020);
    assign push       = wr_en & wr_ready;
    assign pop        = (state == DATA) & ddr.ddr_wdata_req;
    assign ddr.ddr_wr_len = LEN_WIDTH'(BPL);

    always_ff @(posedge ddr_clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            wr_fsync_d     <= 1'b0;
            wdone_d        <= 1'b0;
            fs_pend        <= 1'b0;
            frame_full     <= 1'b0;
            beat_cnt       <= '0;
            line_cnt       <= '0;
            line_addr      <= '0;
            ddr.ddr_wreq   <= 1'b0;
            ddr.ddr_waddr  <= '0;
            ddr.ddr_wdata  <= '0;
            o_wr_frame_bit <= 1'b0;
            o_frame_done   <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            wr_fsync_d   <= wr_fsync;
            wdone_d      <= ddr.ddr_wdone;
            o_frame_done <= 1'b0;
            if (wr_en & ~wr_ready) o_overflow <= 1'b1;
            if (push) wptr <= wptr + 10'd1;
            // Older word lands in the low half of the beat.
            if (pop) begin
                rptr          <= rptr + 10'd2;
                ddr.ddr_wdata <= {mem[rptr + 10'd1], mem[rptr]};
            end
            case (state)
                IDLE: begin
                    if (fs_rise | fs_pend) begin
                        wptr       <= '0;
                        rptr       <= '0;
                        line_cnt   <= '0;
                        line_addr  <= '0;
                        o_overflow <= 1'b0;
                        fs_pend    <= 1'b0;
                        frame_full <= 1'b0;
                    end else if (init_done & ~frame_full & (fill >= 11'(WPL))) begin
                        state         <= REQ;
                        ddr.ddr_wreq  <= 1'b1;
                        ddr.ddr_waddr <= ADDR_WIDTH'(32'({o_wr_frame_bit, line_addr}) + ADDR_OFFSET);
                        beat_cnt      <= '0;
                    end
                end
                REQ: begin
                    if (fs_rise) fs_pend <= 1'b1;
                    if (ddr.ddr_wrdy) begin
                        ddr.ddr_wreq <= 1'b0;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (fs_rise) fs_pend <= 1'b1;
                    if (pop) begin
                        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                        if (beat_cnt == LEN_WIDTH'(BPL - 1)) state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (fs_rise) fs_pend <= 1'b1;
                    if (wdone_rise) begin
                        state <= IDLE;
                        if (line_cnt == 16'(V_NUM - 1)) begin
                            o_wr_frame_bit <= ~o_wr_frame_bit;
                            o_frame_done   <= 1'b1;
                            line_addr      <= '0;
                            line_cnt       <= '0;
                            frame_full     <= 1'b1;
                        end else begin
                            line_addr <= line_addr + LINE_ADDR_WIDTH'(LINE_STEP);
                            line_cnt  <= line_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb/tb_ddr_frame_writer.sv - directed table-driven bench for ddr_frame_writer (default and small-frame instances)
`timescale 1ns/1ps
module tb_ddr_frame_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic a_init, a_fs, a_en, a_rdy, a_fbit, a_fdone, a_ovf;
    logic [127:0] a_data;
    ddr_frame_writer_if #(.ADDR_WIDTH(27), .LEN_WIDTH(16), .BEAT_WIDTH(256)) a_ddr ();
    ddr_frame_writer dut_a (
        .ddr_clk(clk), .ddr_rstn(rstn), .init_done(a_init), .wr_fsync(a_fs),
        .wr_en(a_en), .wr_data(a_data), .wr_ready(a_rdy), .ddr(a_ddr),
        .o_wr_frame_bit(a_fbit), .o_frame_done(a_fdone), .o_overflow(a_ovf));

    logic b_init, b_fs, b_en, b_rdy, b_fbit, b_fdone, b_ovf;
    logic [127:0] b_data;
    ddr_frame_writer_if #(.ADDR_WIDTH(27), .LEN_WIDTH(16), .BEAT_WIDTH(256)) b_ddr ();
    ddr_frame_writer #(.H_NUM(32), .V_NUM(4)) dut_b (
        .ddr_clk(clk), .ddr_rstn(rstn), .init_done(b_init), .wr_fsync(b_fs),
        .wr_en(b_en), .wr_data(b_data), .wr_ready(b_rdy), .ddr(b_ddr),
        .o_wr_frame_bit(b_fbit), .o_frame_done(b_fdone), .o_overflow(b_ovf));

    int total = 0;
    int bad = 0;
    int b_fd_cnt = 0;
    logic [255:0] a_beats [180];
    logic [255:0] b_last;

    typedef struct { int idx; int hi; int lo; } beat_vec_t;
    typedef struct { logic [26:0] addr; logic fd; logic fbit; int hi; int lo; } line_vec_t;
    beat_vec_t av [4];
    line_vec_t bv [4];

    always @(negedge clk) if (rstn && b_fdone) b_fd_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [255:0] bt(input int hi, input int lo);
        return {128'(hi), 128'(lo)};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_a(input int n, input int base);
        int lost = 0;
        for (int i = 0; i < n; i++) begin
            if (!a_rdy) lost++;
            a_en = 1'b1;
            a_data = 128'(base + i);
            tick();
        end
        a_en = 1'b0;
        chk("a_push_accepted", 256'(lost), 256'd0);
    endtask

    task automatic push_b(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            b_en = 1'b1;
            b_data = 128'(base + i);
            tick();
        end
        b_en = 1'b0;
    endtask

    task automatic wait_wreq_a();
        for (int c = 0; c < 100 && !a_ddr.ddr_wreq; c++) tick();
        if (!a_ddr.ddr_wreq) chk("a_wreq_timeout", 256'(a_ddr.ddr_wreq), 256'd1);
    endtask

    task automatic burst_a(input int fs_beat, input int done_hold, output logic [26:0] addr);
        wait_wreq_a();
        addr = a_ddr.ddr_waddr;
        chk("a_wr_len", 256'(a_ddr.ddr_wr_len), 256'd180);
        a_ddr.ddr_wrdy = 1'b1;
        tick();
        a_ddr.ddr_wrdy = 1'b0;
        chk("a_wreq_fall", 256'(a_ddr.ddr_wreq), 256'd0);
        for (int b = 0; b < 180; b++) begin
            a_ddr.ddr_wdata_req = 1'b1;
            a_fs = (b == fs_beat);
            tick();
            a_beats[b] = a_ddr.ddr_wdata;
        end
        a_ddr.ddr_wdata_req = 1'b0;
        a_fs = 1'b0;
        repeat (2) tick();
        a_ddr.ddr_wdone = 1'b1;
        repeat (done_hold) tick();
        a_ddr.ddr_wdone = 1'b0;
        repeat (2) tick();
    endtask

    task automatic burst_b(output logic [26:0] addr, output logic fd);
        for (int c = 0; c < 100 && !b_ddr.ddr_wreq; c++) tick();
        if (!b_ddr.ddr_wreq) chk("b_wreq_timeout", 256'(b_ddr.ddr_wreq), 256'd1);
        addr = b_ddr.ddr_waddr;
        b_ddr.ddr_wrdy = 1'b1;
        tick();
        b_ddr.ddr_wrdy = 1'b0;
        for (int b = 0; b < 3; b++) begin
            b_ddr.ddr_wdata_req = 1'b1;
            tick();
            b_last = b_ddr.ddr_wdata;
        end
        b_ddr.ddr_wdata_req = 1'b0;
        tick();
        b_ddr.ddr_wdone = 1'b1;
        tick();
        fd = b_fdone;
        b_ddr.ddr_wdone = 1'b0;
        tick();
    endtask

    initial begin
        logic [26:0] addr;
        logic fd;
        int acc;
        av[0] = '{0, 1, 0};
        av[1] = '{1, 3, 2};
        av[2] = '{90, 181, 180};
        av[3] = '{179, 359, 358};
        bv[0] = '{27'd0,  1'b0, 1'b0, 5,  4};
        bv[1] = '{27'd24, 1'b0, 1'b0, 11, 10};
        bv[2] = '{27'd48, 1'b0, 1'b0, 17, 16};
        bv[3] = '{27'd72, 1'b1, 1'b1, 23, 22};

        rstn = 1'b0;
        {a_init, a_fs, a_en, b_init, b_fs, b_en} = '0;
        a_data = '0; b_data = '0;
        {a_ddr.ddr_wrdy, a_ddr.ddr_wdata_req, a_ddr.ddr_wdone} = '0;
        {b_ddr.ddr_wrdy, b_ddr.ddr_wdata_req, b_ddr.ddr_wdone} = '0;
        repeat (3) tick();
        a_init = 1'b1;
        #1;
        chk("rst_wreq", 256'(a_ddr.ddr_wreq), 256'd0);
        chk("rst_waddr", 256'(a_ddr.ddr_waddr), 256'd0);
        chk("rst_len", 256'(a_ddr.ddr_wr_len), 256'd180);
        chk("rst_wdata", a_ddr.ddr_wdata, 256'd0);
        chk("rst_fbit", 256'(a_fbit), 256'd0);
        chk("rst_fdone", 256'(a_fdone), 256'd0);
        chk("rst_ovf", 256'(a_ovf), 256'd0);
        chk("rst_ready", 256'(a_rdy), 256'd0);
        chk("rst_len_small", 256'(b_ddr.ddr_wr_len), 256'd3);
        tick();
        rstn = 1'b1;
        b_init = 1'b1;
        tick();

        // Small frame: four lines, bank toggle, frame_full, then next frame in bank 1
        b_fs = 1'b1; tick(); b_fs = 1'b0; tick();
        push_b(24, 0);
        for (int l = 0; l < 4; l++) begin
            burst_b(addr, fd);
            chk($sformatf("b_line%0d_addr", l), 256'(addr), 256'(bv[l].addr));
            chk($sformatf("b_line%0d_fdone", l), 256'(fd), 256'(bv[l].fd));
            chk($sformatf("b_line%0d_fbit", l), 256'(b_fbit), 256'(bv[l].fbit));
            chk($sformatf("b_line%0d_lastbeat", l), b_last, bt(bv[l].hi, bv[l].lo));
        end
        chk("b_fdone_count", 256'(b_fd_cnt), 256'd1);
        chk("b_ready_full", 256'(b_rdy), 256'd0);
        b_fs = 1'b1; tick(); b_fs = 1'b0; tick();
        chk("b_ready_after_fs", 256'(b_rdy), 256'd1);
        push_b(6, 100);
        burst_b(addr, fd);
        chk("b_bank1_addr", 256'(addr), 256'h200000);
        chk("b_bank1_lastbeat", b_last, bt(105, 104));

        // Single line on the default instance
        a_fs = 1'b1; tick(); a_fs = 1'b0; tick();
        push_a(360, 0);
        burst_a(-1, 1, addr);
        chk("a_line0_addr", 256'(addr), 256'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("a_beat%0d", av[k].idx), a_beats[av[k].idx], bt(av[k].hi, av[k].lo));
        chk("a_wdata_hold", a_ddr.ddr_wdata, bt(359, 358));

        // wdone in IDLE ignored; held wdone counts once
        a_ddr.ddr_wdone = 1'b1; tick(); a_ddr.ddr_wdone = 1'b0; tick();
        push_a(360, 360);
        burst_a(-1, 5, addr);
        chk("a_line1_addr", 256'(addr), 256'd1440);
        chk("a_line1_beat0", a_beats[0], bt(361, 360));

        // Frame sync mid-DATA: burst completes, leftovers discarded, same bank restarts
        push_a(370, 1000);
        burst_a(50, 1, addr);
        chk("a_line2_addr", 256'(addr), 256'd2880);
        chk("a_fsmid_lastbeat", a_beats[179], bt(1359, 1358));
        chk("a_fsmid_fbit", 256'(a_fbit), 256'd0);
        push_a(360, 3000);
        burst_a(-1, 1, addr);
        chk("a_fsmid_next_addr", 256'(addr), 256'd0);
        chk("a_fsmid_next_beat0", a_beats[0], bt(3001, 3000));
        chk("a_fsmid_next_fbit", 256'(a_fbit), 256'd0);

        // Backpressure: fill stops at 1020, rejected push leaves FIFO intact
        acc = 0;
        for (int i = 0; i < 1100; i++) begin
            if (!a_rdy) break;
            a_en = 1'b1;
            a_data = 128'(5000 + acc);
            tick();
            acc++;
        end
        a_en = 1'b0;
        chk("a_bp_accepted", 256'(acc), 256'd1020);
        chk("a_bp_ovf_before", 256'(a_ovf), 256'd0);
        a_en = 1'b1; a_data = 128'hDEAD; tick(); a_en = 1'b0;
        chk("a_bp_ovf", 256'(a_ovf), 256'd1);
        burst_a(-1, 1, addr);
        chk("a_bp_l1_addr", 256'(addr), 256'd1440);
        chk("a_bp_l1_beat0", a_beats[0], bt(5001, 5000));
        burst_a(-1, 1, addr);
        chk("a_bp_l2_addr", 256'(addr), 256'd2880);
        push_a(60, 6000);
        burst_a(-1, 1, addr);
        chk("a_bp_l3_addr", 256'(addr), 256'd4320);
        chk("a_bp_beat149", a_beats[149], bt(6019, 6018));
        chk("a_bp_beat150", a_beats[150], bt(6001, 6000));

        // Reset mid-burst
        push_a(360, 7000);
        wait_wreq_a();
        a_ddr.ddr_wrdy = 1'b1; tick(); a_ddr.ddr_wrdy = 1'b0;
        a_ddr.ddr_wdata_req = 1'b1;
        repeat (10) tick();
        rstn = 1'b0;
        #1;
        chk("a_rstmid_wreq", 256'(a_ddr.ddr_wreq), 256'd0);
        chk("a_rstmid_ready", 256'(a_rdy), 256'd0);
        chk("a_rstmid_wdata", a_ddr.ddr_wdata, 256'd0);
        chk("a_rstmid_ovf", 256'(a_ovf), 256'd0);
        chk("b_rstmid_fbit", 256'(b_fbit), 256'd0);
        a_ddr.ddr_wdata_req = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        push_a(360, 8000);
        burst_a(-1, 1, addr);
        chk("a_postrst_addr", 256'(addr), 256'd0);
        chk("a_postrst_beat0", a_beats[0], bt(8001, 8000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
